// File: rtl/uart_pkt_ctrl_pkg.sv
// Shared types and constants for the UART packet receive controller:
// FSM states, error cause codes, default sync marker and an index-width helper.
package uart_pkt_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_pkt_ctrl_pkt_buf.sv
// Payload storage: synchronous write, combinational read so it maps onto LUT RAM.
module pkt_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [7:0]       rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_pkt_ctrl.sv
// Receive-side packet controller: edge-detects byte_available, parses
// SYNC/LEN/PAYLOAD/CSUM frames and drains checked payloads over valid/ready.
module uart_pkt_ctrl
    import uart_pkt_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 12000000,
    parameter int unsigned MAX_LEN      = 16,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CLKS = 12000
) (
    input  logic       clk,
    input  logic       rst,
    output logic       rx_enable,
    input  logic [7:0] rx_byte,
    input  logic       byte_available,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic       pkt_last,
    output logic [7:0] pkt_len,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int unsigned IDX_W = idx_width(MAX_LEN);
    // A zero TIMEOUT_CLKS falls back to 1 ms derived from the clock rate.
    localparam int unsigned TMO_LIMIT = (TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS :
                                        ((CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1);
    localparam int unsigned TMO_W = $clog2(TMO_LIMIT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LIMIT - 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t           state_reg, state_next;
    logic             ba_reg;
    logic [7:0]       len_reg, len_next;
    logic [7:0]       csum_reg, csum_next;
    logic [IDX_W-1:0] wr_idx_reg, wr_idx_next;
    logic [IDX_W-1:0] rd_idx_reg, rd_idx_next;
    logic [TMO_W-1:0] tmo_reg, tmo_next;
    logic [7:0]       pkt_len_reg, pkt_len_next;
    logic             err_reg, err_next;
    logic [1:0]       err_code_reg, err_code_next;

    logic       strobe;
    logic       in_rx;
    logic       wr_last;
    logic       rd_last;
    logic       buf_we;
    logic [7:0] rd_data;

    assign strobe  = byte_available & ~ba_reg;
    assign in_rx   = (state_reg == S_LEN) || (state_reg == S_PAYLOAD) || (state_reg == S_CSUM);
    assign wr_last = (8'(wr_idx_reg) == (len_reg - 8'd1));
    assign rd_last = (8'(rd_idx_reg) == (len_reg - 8'd1));

    pkt_buf #(
        .DEPTH (MAX_LEN),
        .IDX_W (IDX_W)
    ) u_pkt_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_idx_reg),
        .wdata (rx_byte),
        .raddr (rd_idx_reg),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            ba_reg       <= 1'b0;
            len_reg      <= 8'd0;
            csum_reg     <= 8'd0;
            wr_idx_reg   <= '0;
            rd_idx_reg   <= '0;
            tmo_reg      <= '0;
            pkt_len_reg  <= 8'd0;
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
        end else begin
            state_reg    <= state_next;
            ba_reg       <= byte_available;
            len_reg      <= len_next;
            csum_reg     <= csum_next;
            wr_idx_reg   <= wr_idx_next;
            rd_idx_reg   <= rd_idx_next;
            tmo_reg      <= tmo_next;
            pkt_len_reg  <= pkt_len_next;
            err_reg      <= err_next;
            err_code_reg <= err_code_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        csum_next     = csum_reg;
        wr_idx_next   = wr_idx_reg;
        rd_idx_next   = rd_idx_reg;
        tmo_next      = '0;
        pkt_len_next  = pkt_len_reg;
        err_next      = 1'b0;
        err_code_next = err_code_reg;
        buf_we        = 1'b0;

        // Timeout only applies while waiting on a frame byte; a strobe in the
        // same cycle is handled below and overrides this.
        if (in_rx && !strobe) begin
            if (tmo_reg == TMO_LAST) begin
                state_next    = S_IDLE;
                err_next      = 1'b1;
                err_code_next = ERR_TIMEOUT;
            end else begin
                tmo_next = tmo_reg + TMO_W'(1);
            end
        end

        case (state_reg)
            S_IDLE: begin
                if (strobe && (rx_byte == SYNC_BYTE)) begin
                    state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (strobe) begin
                    if ((rx_byte == 8'd0) || (rx_byte > MAX_LEN_B)) begin
                        state_next    = S_IDLE;
                        err_next      = 1'b1;
                        err_code_next = ERR_LEN;
                    end else begin
                        state_next  = S_PAYLOAD;
                        len_next    = rx_byte;
                        csum_next   = rx_byte;
                        wr_idx_next = '0;
                    end
                end
            end
            S_PAYLOAD: begin
                if (strobe) begin
                    buf_we    = 1'b1;
                    csum_next = csum_reg ^ rx_byte;
                    if (wr_last) begin
                        state_next = S_CSUM;
                    end else begin
                        wr_idx_next = wr_idx_reg + IDX_W'(1);
                    end
                end
            end
            S_CSUM: begin
                if (strobe) begin
                    if (rx_byte == csum_reg) begin
                        state_next   = S_DRAIN;
                        rd_idx_next  = '0;
                        pkt_len_next = len_reg;
                    end else begin
                        state_next    = S_IDLE;
                        err_next      = 1'b1;
                        err_code_next = ERR_CSUM;
                    end
                end
            end
            S_DRAIN: begin
                if (pkt_ready) begin
                    if (rd_last) begin
                        state_next  = S_IDLE;
                        rd_idx_next = '0;
                    end else begin
                        rd_idx_next = rd_idx_reg + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign rx_enable = ~rst & (state_reg != S_DRAIN);
    assign pkt_valid = (state_reg == S_DRAIN);
    assign pkt_data  = pkt_valid ? rd_data : 8'h00;
    assign pkt_last  = pkt_valid & rd_last;
    assign pkt_len   = pkt_len_reg;
    assign err       = err_reg;
    assign err_code  = err_code_reg;

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Directed bench for uart_pkt_ctrl: good/bad packets, backpressure,
// held byte_available, timeout latency and mid-packet reset.
module tb_uart_pkt_ctrl;

    localparam int TMO = 12000;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_enable;
    logic [7:0] rx_byte;
    logic       byte_available;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_ready;
    logic       pkt_last;
    logic [7:0] pkt_len;
    logic       err;
    logic [1:0] err_code;

    int n_tests = 0;
    int n_fail  = 0;
    int err_seen = 0;

    uart_pkt_ctrl #(
        .CLK_HZ       (12000000),
        .MAX_LEN      (16),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_enable      (rx_enable),
        .rx_byte        (rx_byte),
        .byte_available (byte_available),
        .pkt_data       (pkt_data),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .pkt_last       (pkt_last),
        .pkt_len        (pkt_len),
        .err            (err),
        .err_code       (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (err === 1'b1) err_seen <= err_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge right after the strobe edge.
    task automatic strobe_byte(input logic [7:0] b);
        rx_byte = b;
        byte_available = 1'b1;
        @(negedge clk);
        byte_available = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        strobe_byte(b);
        @(negedge clk);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        rx_byte = 8'h00;
        byte_available = 1'b0;
        pkt_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_rx_enable", rx_enable, 0);
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_pkt_last", pkt_last, 0);
        chk("rst_pkt_data", pkt_data, 8'h00);
        chk("rst_pkt_len", pkt_len, 8'h00);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rx_enable_after_rst", rx_enable, 1);

        // Good packet A5 03 11 22 33 03, ready held high
        pkt_ready = 1'b1;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        strobe_byte(8'h03);
        chk("good_valid0", pkt_valid, 1);
        chk("good_data0", pkt_data, 8'h11);
        chk("good_last0", pkt_last, 0);
        chk("good_len", pkt_len, 8'd3);
        chk("good_rxen_drain", rx_enable, 0);
        @(negedge clk);
        chk("good_data1", pkt_data, 8'h22);
        chk("good_last1", pkt_last, 0);
        @(negedge clk);
        chk("good_data2", pkt_data, 8'h33);
        chk("good_last2", pkt_last, 1);
        @(negedge clk);
        chk("good_valid_end", pkt_valid, 0);
        chk("good_rxen_end", rx_enable, 1);
        chk("good_no_err", err_seen, 0);

        // SYNC one cycle after DRAIN->IDLE, then LEN 00 -> LEN error
        strobe_byte(8'hA5);
        @(negedge clk);
        strobe_byte(8'h00);
        chk("len0_err", err, 1);
        chk("len0_code", err_code, 1);
        @(negedge clk);
        chk("len0_err_width", err, 0);
        chk("len0_no_valid", pkt_valid, 0);

        // LEN 0x11 > MAX_LEN
        send(8'hA5);
        strobe_byte(8'h11);
        chk("len17_err", err, 1);
        chk("len17_code", err_code, 1);
        @(negedge clk);
        chk("len17_err_width", err, 0);
        chk("len_err_count", err_seen, 2);

        // Recovery packet A5 01 7E 7F
        send(8'hA5); send(8'h01); send(8'h7E);
        strobe_byte(8'h7F);
        chk("rec_valid", pkt_valid, 1);
        chk("rec_data", pkt_data, 8'h7E);
        chk("rec_last", pkt_last, 1);
        chk("rec_len", pkt_len, 8'd1);
        @(negedge clk);
        chk("rec_valid_end", pkt_valid, 0);

        // Bad checksum A5 02 AA 55 00 (correct would be FD)
        send(8'hA5); send(8'h02); send(8'hAA); send(8'h55);
        strobe_byte(8'h00);
        chk("csum_err", err, 1);
        chk("csum_code", err_code, 2);
        chk("csum_no_valid", pkt_valid, 0);
        @(negedge clk);
        chk("csum_err_width", err, 0);
        chk("csum_rxen_idle", rx_enable, 1);
        chk("csum_err_count", err_seen, 3);

        // Backpressure, plus an A5 arriving mid-drain
        pkt_ready = 1'b0;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        strobe_byte(8'h03);
        chk("bp_valid0", pkt_valid, 1);
        chk("bp_data0", pkt_data, 8'h11);
        rx_byte = 8'hA5;
        byte_available = 1'b1;
        @(negedge clk);
        chk("bp_hold0", pkt_data, 8'h11);
        chk("bp_rxen0", rx_enable, 0);
        byte_available = 1'b0;
        pkt_ready = 1'b1;
        @(negedge clk);
        chk("bp_data1", pkt_data, 8'h22);
        pkt_ready = 1'b0;
        @(negedge clk);
        chk("bp_hold1", pkt_data, 8'h22);
        chk("bp_valid1", pkt_valid, 1);
        chk("bp_rxen1", rx_enable, 0);
        pkt_ready = 1'b1;
        @(negedge clk);
        chk("bp_data2", pkt_data, 8'h33);
        chk("bp_last2", pkt_last, 1);
        pkt_ready = 1'b0;
        @(negedge clk);
        chk("bp_hold2", pkt_data, 8'h33);
        chk("bp_valid2", pkt_valid, 1);
        chk("bp_rxen2", rx_enable, 0);
        pkt_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_end", pkt_valid, 0);
        chk("bp_rxen_end", rx_enable, 1);
        strobe_byte(8'h00);
        @(negedge clk);
        chk("bp_sync_ignored", err_seen, 3);

        // byte_available held 5 cycles gives one byte each
        send(8'hA5);
        rx_byte = 8'h01;
        byte_available = 1'b1;
        repeat (5) @(negedge clk);
        byte_available = 1'b0;
        @(negedge clk);
        rx_byte = 8'h5A;
        byte_available = 1'b1;
        repeat (5) @(negedge clk);
        byte_available = 1'b0;
        @(negedge clk);
        strobe_byte(8'h5B);
        chk("hold_valid", pkt_valid, 1);
        chk("hold_data", pkt_data, 8'h5A);
        chk("hold_len", pkt_len, 8'd1);
        @(negedge clk);
        chk("hold_valid_end", pkt_valid, 0);

        // Timeout: A5 02 10 then silence
        send(8'hA5); send(8'h02);
        strobe_byte(8'h10);
        k = 0;
        for (int i = 1; i <= TMO + 50; i++) begin
            @(negedge clk);
            if (err === 1'b1) begin
                k = i;
                break;
            end
        end
        chk("tmo_latency", k, TMO);
        chk("tmo_code", err_code, 3);
        @(negedge clk);
        chk("tmo_err_width", err, 0);
        chk("tmo_rxen", rx_enable, 1);

        // Reset mid-payload
        send(8'hA5); send(8'h04); send(8'h01);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rxen", rx_enable, 0);
        chk("mid_rst_valid", pkt_valid, 0);
        chk("mid_rst_last", pkt_last, 0);
        chk("mid_rst_data", pkt_data, 8'h00);
        chk("mid_rst_len", pkt_len, 8'h00);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_code", err_code, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rxen", rx_enable, 1);
        send(8'hA5); send(8'h01); send(8'h7E);
        strobe_byte(8'h7F);
        chk("post_rst_valid", pkt_valid, 1);
        chk("post_rst_data", pkt_data, 8'h7E);
        @(negedge clk);
        chk("total_err_pulses", err_seen, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
